// File: rtl/scarv_cop_pkg.sv
// Shared constants and types for the COP register-file write-port controller.
package scarv_cop_pkg;

  localparam int unsigned CPRS_NREGS = 16;
  localparam int unsigned CPRS_AW    = 4;
  localparam int unsigned CPRS_DW    = 32;
  localparam int unsigned CPRS_BW    = CPRS_DW / 8;

  // One register-file write: byte-lane enables, destination, data.
  typedef struct packed {
    logic [CPRS_BW-1:0] wen;
    logic [CPRS_AW-1:0] addr;
    logic [CPRS_DW-1:0] wdata;
  } cprs_wr_t;

  // Write-controller sequencing states.
  typedef enum logic [1:0] {
    WCTL_IDLE = 2'd0,
    WCTL_INIT = 2'd1,
    WCTL_DONE = 2'd2
  } wctl_state_t;

endpackage

// File: rtl/scarv_cop_rr_arb.sv
// Combinational round-robin arbiter: grants the first asserted request
// found searching from ptr upwards, wrapping modulo N. The pointer is
// owned by the instantiating block.
module scarv_cop_rr_arb #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  // Priority search starting at ptr; first hit wins.
  always_comb begin
    logic        found;
    int unsigned pos;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = 0;
    for (int unsigned off = 0; off < N; off++) begin
      pos = (32'(ptr) + off) % N;
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        gnt_idx  = PW'(pos);
      end
    end
  end

endmodule

// File: rtl/scarv_cop_cprs_wctl.sv
// Write-port controller for the COP GPR file: round-robin arbitration of
// writeback sources onto one registered write port, plus xc.init sequencing
// that clears every register one per cycle.
module scarv_cop_cprs_wctl
  import scarv_cop_pkg::*;
#(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned NREGS = CPRS_NREGS,
  parameter int unsigned AW    = CPRS_AW,
  parameter int unsigned DW    = CPRS_DW
) (
  input  logic                   g_clk,
  input  logic                   g_reset,
  output logic                   g_clk_req,
  input  logic                   init_req,
  output logic                   init_done,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*(DW/8)-1:0] req_wen,
  input  logic [NREQ*AW-1:0]     req_addr,
  input  logic [NREQ*DW-1:0]     req_wdata,
  output logic [DW/8-1:0]        crd_wen,
  output logic [AW-1:0]          crd_addr,
  output logic [DW-1:0]          crd_wdata
);

  localparam int unsigned BW = DW / 8;
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  wctl_state_t     state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            init_done_q, init_done_d;
  cprs_wr_t        crd_q, crd_d;

  logic [NREQ-1:0] arb_gnt;
  logic [PW-1:0]   arb_idx;
  logic            grant_en;
  logic            xfer;
  cprs_wr_t        sel_wr;

  scarv_cop_rr_arb #(
    .N  (NREQ),
    .PW (PW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Grants only in IDLE without a pending init, and never during reset.
  always_comb begin
    grant_en  = (state_q == WCTL_IDLE) && !init_req && !g_reset;
    req_ready = grant_en ? arb_gnt : '0;
    xfer      = |req_ready;
  end

  // One-hot payload mux for the granted requester.
  always_comb begin
    sel_wr = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        sel_wr.wen   = req_wen[i*BW +: BW];
        sel_wr.addr  = req_addr[i*AW +: AW];
        sel_wr.wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  // Next-state, counter, pointer and write-port payload.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    init_done_d = init_done_q;
    crd_d       = '0;
    unique case (state_q)
      WCTL_IDLE: begin
        if (init_req) begin
          state_d = WCTL_INIT;
          cnt_d   = '0;
        end else if (xfer) begin
          crd_d    = sel_wr;
          rr_ptr_d = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + PW'(1);
        end
      end
      WCTL_INIT: begin
        if (!init_req) begin
          // Abort: nothing issued on this edge, counter restarts next time.
          state_d = WCTL_IDLE;
          cnt_d   = '0;
        end else begin
          crd_d.wen   = '1;
          crd_d.addr  = cnt_q;
          crd_d.wdata = '0;
          if (cnt_q == AW'(NREGS - 1)) begin
            state_d = WCTL_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      WCTL_DONE: begin
        if (!init_req) begin
          state_d     = WCTL_IDLE;
          init_done_d = 1'b0;
        end else begin
          // Set one cycle after entry so the final clear has committed.
          init_done_d = 1'b1;
        end
      end
      default: begin
        state_d = WCTL_IDLE;
      end
    endcase
  end

  // State and registered write port, asynchronously reset.
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q     <= WCTL_IDLE;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      init_done_q <= 1'b0;
      crd_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      init_done_q <= init_done_d;
      crd_q       <= crd_d;
    end
  end

  // Output drive and clock request.
  always_comb begin
    crd_wen   = crd_q.wen;
    crd_addr  = crd_q.addr;
    crd_wdata = crd_q.wdata;
    init_done = init_done_q;
    g_clk_req = (|req_valid) | init_req | (state_q != WCTL_IDLE) | (|crd_q.wen);
  end

  // Requesters must hold valid and payload until accepted.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_hold_chk
    a_hold : assert property (@(posedge g_clk) disable iff (g_reset)
      (req_valid[gi] && !req_ready[gi]) |=>
        (req_valid[gi] &&
         $stable(req_wen[gi*BW +: BW]) &&
         $stable(req_addr[gi*AW +: AW]) &&
         $stable(req_wdata[gi*DW +: DW])));
  end

endmodule

// File: tb/tb_scarv_cop_cprs_wctl.sv
// Self-checking bench for the COP register-file write-port controller.
module tb_scarv_cop_cprs_wctl;

  localparam int NREQ = 3;
  localparam int BW   = 4;
  localparam int AW   = 4;
  localparam int DW   = 32;

  logic                 g_clk = 1'b0;
  logic                 g_reset;
  logic                 g_clk_req;
  logic                 init_req;
  logic                 init_done;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*BW-1:0]   req_wen;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [BW-1:0]        crd_wen;
  logic [AW-1:0]        crd_addr;
  logic [DW-1:0]        crd_wdata;

  int checks = 0;
  int errors = 0;

  always #5 g_clk = ~g_clk;

  scarv_cop_cprs_wctl #(
    .NREQ  (NREQ),
    .NREGS (16),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .g_clk_req (g_clk_req),
    .init_req  (init_req),
    .init_done (init_done),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .crd_wen   (crd_wen),
    .crd_addr  (crd_addr),
    .crd_wdata (crd_wdata)
  );

  // Register-file model: commits whatever is on crd_* at each edge.
  logic [31:0] rf [16] = '{default: 32'hFFFF_FFFF};
  always @(posedge g_clk) begin
    for (int b = 0; b < BW; b++)
      if (crd_wen[b]) rf[crd_addr][8*b +: 8] <= crd_wdata[8*b +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] w, input logic [3:0] a, input logic [31:0] d);
    req_wen[i*BW +: BW]   = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    g_reset   = 1'b1;
    req_valid = '0;
    init_req  = 1'b0;
    tick();
    tick();
    g_reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  exp_ready;
    logic [3:0]  exp_wen;
    logic [3:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt [12];

  // Random-test reference state: one pending item per requester.
  bit          cv [3];
  logic [3:0]  cw [3];
  logic [3:0]  ca [3];
  logic [31:0] cd [3];
  int          mptr;

  initial begin
    int g;
    logic [2:0] v;

    // Arbitration vectors from reset (pointer 0); payload of requester i:
    // wen {F,3,0}[i], addr 4+i, data A000_0000+i.
    vt[0]  = '{3'b001, 3'b001, 4'hF, 4'd4, 32'hA000_0000};
    vt[1]  = '{3'b110, 3'b010, 4'h3, 4'd5, 32'hA000_0001};
    vt[2]  = '{3'b100, 3'b100, 4'h0, 4'd6, 32'hA000_0002};
    vt[3]  = '{3'b000, 3'b000, 4'h0, 4'd0, 32'h0};
    vt[4]  = '{3'b101, 3'b001, 4'hF, 4'd4, 32'hA000_0000};
    vt[5]  = '{3'b100, 3'b100, 4'h0, 4'd6, 32'hA000_0002};
    vt[6]  = '{3'b010, 3'b010, 4'h3, 4'd5, 32'hA000_0001};
    vt[7]  = '{3'b011, 3'b001, 4'hF, 4'd4, 32'hA000_0000};
    vt[8]  = '{3'b010, 3'b010, 4'h3, 4'd5, 32'hA000_0001};
    vt[9]  = '{3'b111, 3'b100, 4'h0, 4'd6, 32'hA000_0002};
    vt[10] = '{3'b011, 3'b001, 4'hF, 4'd4, 32'hA000_0000};
    vt[11] = '{3'b010, 3'b010, 4'h3, 4'd5, 32'hA000_0001};

    g_reset   = 1'b1;
    init_req  = 1'b0;
    req_valid = 3'b111;
    req_wen   = '0;
    req_addr  = '0;
    req_wdata = '0;
    #2;
    chk("ready_in_reset", {29'b0, req_ready}, 32'h0);
    tick();
    tick();
    chk("rst_crd_wen", {28'b0, crd_wen}, 32'h0);
    chk("rst_crd_addr", {28'b0, crd_addr}, 32'h0);
    chk("rst_crd_wdata", crd_wdata, 32'h0);
    chk("rst_init_done", {31'b0, init_done}, 32'h0);
    req_valid = '0;
    tick();
    g_reset = 1'b0;
    #1;
    chk("idle_clk_req", {31'b0, g_clk_req}, 32'h0);

    // Single write from requester 1.
    set_req(1, 4'hF, 4'd3, 32'hDEADBEEF);
    req_valid = 3'b010;
    #1;
    chk("t1_ready", {29'b0, req_ready}, 32'h2);
    chk("t1_clk_req", {31'b0, g_clk_req}, 32'h1);
    tick();
    req_valid = '0;
    chk("t1_wen", {28'b0, crd_wen}, 32'hF);
    chk("t1_addr", {28'b0, crd_addr}, 32'h3);
    chk("t1_data", crd_wdata, 32'hDEADBEEF);
    tick();
    chk("t1_wen_off", {28'b0, crd_wen}, 32'h0);

    // All three held valid: rotation 0,1,2,0,1,2; drop each after its last grant.
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 4'hF, 4'(8 + i), 32'h2000_0000 + i);
    v = 3'b111;
    req_valid = v;
    for (int c = 0; c < 6; c++) begin
      g = c % 3;
      #1;
      chk("t2_ready", {29'b0, req_ready}, 32'(1 << g));
      tick();
      if (c >= 3) v[g] = 1'b0;
      req_valid = v;
      chk("t2_addr", {28'b0, crd_addr}, 32'(8 + g));
      chk("t2_data", crd_wdata, 32'h2000_0000 + g);
    end

    // Table-driven arbitration vectors.
    do_reset();
    set_req(0, 4'hF, 4'd4, 32'hA000_0000);
    set_req(1, 4'h3, 4'd5, 32'hA000_0001);
    set_req(2, 4'h0, 4'd6, 32'hA000_0002);
    for (int n = 0; n < 12; n++) begin
      req_valid = vt[n].valid;
      #1;
      chk("tab_ready", {29'b0, req_ready}, {29'b0, vt[n].exp_ready});
      tick();
      chk("tab_wen", {28'b0, crd_wen}, {28'b0, vt[n].exp_wen});
      if (vt[n].exp_wen != 4'h0) begin
        chk("tab_addr", {28'b0, crd_addr}, {28'b0, vt[n].exp_addr});
        chk("tab_data", crd_wdata, vt[n].exp_data);
      end
    end
    req_valid = '0;

    // Full xc.init with no requests.
    do_reset();
    init_req = 1'b1;
    #1;
    chk("t3_clk_req", {31'b0, g_clk_req}, 32'h1);
    tick();
    chk("t3_e0_wen", {28'b0, crd_wen}, 32'h0);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("t3_wen", {28'b0, crd_wen}, 32'hF);
      chk("t3_addr", {28'b0, crd_addr}, 32'(k));
      chk("t3_data", crd_wdata, 32'h0);
      chk("t3_done_early", {31'b0, init_done}, 32'h0);
    end
    tick();
    chk("t3_done", {31'b0, init_done}, 32'h1);
    chk("t3_wen_after", {28'b0, crd_wen}, 32'h0);
    for (int r = 0; r < 16; r++) chk("t3_rf_zero", rf[r], 32'h0);
    tick();
    chk("t3_done_hold", {31'b0, init_done}, 32'h1);
    init_req = 1'b0;
    tick();
    chk("t3_done_clr", {31'b0, init_done}, 32'h0);
    chk("t3_clk_req_off", {31'b0, g_clk_req}, 32'h0);

    // Init arriving while requesters 0 and 2 are pending; pointer preserved.
    do_reset();
    set_req(0, 4'hF, 4'd1, 32'hC000_0000);
    set_req(2, 4'hF, 4'd2, 32'hC000_0002);
    req_valid = 3'b001;
    #1;
    chk("t4_pre_ready", {29'b0, req_ready}, 32'h1);
    tick();
    init_req  = 1'b1;
    req_valid = 3'b101;
    #1;
    chk("t4_ready_init", {29'b0, req_ready}, 32'h0);
    chk("t4_pre_addr", {28'b0, crd_addr}, 32'h1);
    chk("t4_pre_wen", {28'b0, crd_wen}, 32'hF);
    for (int n = 0; n < 20; n++) begin
      tick();
      chk("t4_ready_busy", {29'b0, req_ready}, 32'h0);
    end
    init_req = 1'b0;
    #1;
    chk("t4_ready_done", {29'b0, req_ready}, 32'h0);
    tick();
    chk("t4_resume2", {29'b0, req_ready}, 32'h4);
    tick();
    req_valid = 3'b001;
    chk("t4_addr2", {28'b0, crd_addr}, 32'h2);
    #1;
    chk("t4_resume0", {29'b0, req_ready}, 32'h1);
    tick();
    req_valid = '0;
    chk("t4_addr0", {28'b0, crd_addr}, 32'h1);

    // Abort after reg 5, then a fresh init restarts at reg 0.
    do_reset();
    init_req = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t5_addr", {28'b0, crd_addr}, 32'(k));
    end
    init_req = 1'b0;
    tick();
    chk("t5_abort_wen", {28'b0, crd_wen}, 32'h0);
    for (int n = 0; n < 20; n++) begin
      tick();
      chk("t5_no_done", {31'b0, init_done}, 32'h0);
    end
    init_req = 1'b1;
    tick();
    tick();
    chk("t5_re_wen", {28'b0, crd_wen}, 32'hF);
    chk("t5_re_addr", {28'b0, crd_addr}, 32'h0);
    tick();
    chk("t5_re_addr1", {28'b0, crd_addr}, 32'h1);
    init_req = 1'b0;
    tick();
    chk("t5_re_abort", {28'b0, crd_wen}, 32'h0);

    // Reset pulse with cnt=9 (reg 8 on the port).
    do_reset();
    init_req = 1'b1;
    tick();
    for (int k = 0; k < 9; k++) tick();
    chk("t6_addr8", {28'b0, crd_addr}, 32'h8);
    g_reset = 1'b1;
    #1;
    chk("t6_wen", {28'b0, crd_wen}, 32'h0);
    chk("t6_done", {31'b0, init_done}, 32'h0);
    init_req = 1'b0;
    tick();
    g_reset = 1'b0;
    set_req(0, 4'hF, 4'd7, 32'h6000_0000);
    set_req(1, 4'hF, 4'd9, 32'h6000_0001);
    req_valid = 3'b011;
    #1;
    chk("t6_ptr0", {29'b0, req_ready}, 32'h1);
    tick();
    req_valid = 3'b010;
    chk("t6_addr", {28'b0, crd_addr}, 32'h7);
    #1;
    chk("t6_next", {29'b0, req_ready}, 32'h2);
    tick();
    req_valid = '0;
    chk("t6_addr1", {28'b0, crd_addr}, 32'h9);

    // Randomized traffic against a pending-item model.
    do_reset();
    mptr = 0;
    for (int i = 0; i < 3; i++) cv[i] = 1'b0;
    for (int cyc = 0; cyc < 610; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (!cv[i] && cyc < 600 && $urandom_range(0, 1) == 1) begin
          cv[i] = 1'b1;
          cw[i] = 4'($urandom_range(0, 15));
          ca[i] = 4'($urandom_range(0, 15));
          cd[i] = $urandom;
        end
        req_valid[i] = cv[i];
        if (cv[i]) set_req(i, cw[i], ca[i], cd[i]);
      end
      g = -1;
      for (int off = 0; off < 3; off++)
        if (g < 0 && cv[(mptr + off) % 3]) g = (mptr + off) % 3;
      #1;
      chk("rnd_ready", {29'b0, req_ready}, (g < 0) ? 32'h0 : 32'(1 << g));
      tick();
      if (g >= 0) begin
        chk("rnd_wen", {28'b0, crd_wen}, {28'b0, cw[g]});
        if (cw[g] != 4'h0) begin
          chk("rnd_addr", {28'b0, crd_addr}, {28'b0, ca[g]});
          chk("rnd_data", crd_wdata, cd[g]);
        end
        cv[g] = 1'b0;
        mptr  = (g + 1) % 3;
      end else begin
        chk("rnd_idle_wen", {28'b0, crd_wen}, 32'h0);
      end
    end
    req_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
